align_acc_scheduler: RTL and testbench
======================================

// Module: align_acc_scheduler
// PURPOSE
//  Sequencer for one SD4 MAC group. Buffers N_PP (exponent, sign-magnitude partial
//  product) pairs and tracks their maximum exponent. It then replays the pairs one per
//  cycle through an internal alignment instance (u_align) and accumulates the aligned
//  16-bit values. Sits between the partial-product generator and the MAC normaliser.
// PARAMETERS
//  N_PP   8   partial products per group; power of two, >=2
//  ACC_W  19  accumulator width; must be >= 16+log2(N_PP)
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  in_valid     in   1      input pair valid
//  in_ready     out  1      block can accept a pair (high only in LOAD)
//  in_exp       in   5      exponent, unsigned
//  in_pp        in   5      sign-magnitude pp: [4]=sign, [3:0]=magnitude
//  out_valid    out  1      group result valid
//  out_ready    in   1      downstream accepts result
//  out_sum      out  ACC_W  signed sum of aligned pps
//  out_exp_max  out  5      max exponent of the group (scale of out_sum)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=LOAD, idx=0, exp_max=0, acc=0, out_valid=0,
//   out_sum=0, out_exp_max=0; in_ready=1 while in reset. All regs are cleared at once.
//  FSM LOAD -> ALIGN -> DONE -> LOAD.
//  LOAD: in_ready=1. Each in_valid&in_ready edge writes buf[idx]={in_exp,in_pp}
//   and sets exp_max=max(exp_max,in_exp) (unsigned), then idx++.
//   Beat idx==N_PP-1 -> ALIGN with idx=0. No beats are dropped; in_valid low stalls.
//  ALIGN: in_ready=0. u_align gets exp=buf[idx].exp, exp_max=exp_max, signed_pp=buf[idx].pp.
//   Each edge: acc += sign-extended aligned_pp; idx++. Edge at idx==N_PP-1 -> DONE.
//   out_sum<=final acc, out_exp_max<=exp_max.
//  Latency: out_valid rises exactly N_PP edges after the edge accepting the last beat.
//  Per-pair arithmetic (u_align): d=exp_max-exp (0..31);
//   mag=({m,11'b0}>>d), 15 bits; value = sign ? -mag : +mag.
//   d>=15 gives 0. Sign=1 with m=0 (negative zero) gives 0.
//   The accumulator never overflows when ACC_W is legal; there is no saturation logic.
//  DONE: out_valid=1. out_sum and out_exp_max are held stable until out_valid&out_ready.
//   That edge -> LOAD with idx=0, exp_max=0, acc=0, out_valid=0.
//   in_ready stays 0 in DONE, so the next group's first beat is accepted no earlier
//   than the edge after the result handshake.
//  out_ready is ignored outside DONE. in_valid is ignored outside LOAD.
//  Reset mid-group (LOAD/ALIGN/DONE): partial group is discarded, no out_valid pulse.
//   After release the next beat is treated as beat 0.
//  Buffer contents are not reset; they are only read after being written in this group.
// TESTING
//  1 8x(exp=10,pp=+1), out_ready=1 -> out_exp_max=10, out_sum=16384,
//    out_valid 8 edges after last beat.
//  2 (10,+3),(8,-4), 6x(10,+0) -> aligned 6144 and -2048; out_sum=4096, out_exp_max=10.
//  3 (20,+15), 7x(3,+15) -> d=17, so 7 pairs add 0; out_sum=30720, out_exp_max=20.
//  4 (5,-0),(5,-1), 6x(5,+0) -> out_sum=-2048 (negative zero contributes 0).
//  5 Hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> out_sum held,
//    in_ready=0, no beat taken until the handshake.
//  6 rst_n low during ALIGN (idx=3), then a fresh group of 8x(1,+2) -> out_sum=32768
//    (8x(2<<11)); no out_valid from the aborted group.

Source files
------------

// File: rtl/align_acc_scheduler.sv
// SD4 MAC group sequencer. It collects N_PP (exponent, sign-magnitude pp) pairs,
// tracks their largest exponent, then replays the pairs one per cycle through
// the aligner and accumulates the aligned values into a single signed sum.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  LOAD  | accept pairs into the buffer and track the maximum exponent
//  ALIGN | replay one buffered pair per cycle through u_align into acc
//  DONE  | present out_sum/out_exp_max until the downstream handshake

// Aligns one sign-magnitude partial product to the group's maximum exponent.
// The magnitude sits at bits [14:11] before the shift, so a shift of 15 or
// more always clears it. A negative zero produces zero.
module align_acc_align (
  input  logic        [4:0]  pp_exp,
  input  logic        [4:0]  exp_max,
  input  logic        [4:0]  signed_pp,
  output logic signed [15:0] aligned_pp
);

  logic [4:0]  shift_d;
  logic [14:0] mag_pre;
  logic [14:0] mag;

  // Shift the magnitude right by the exponent gap and apply the sign.
  always_comb begin
    shift_d    = exp_max - pp_exp;
    mag_pre    = {signed_pp[3:0], 11'b0};
    mag        = mag_pre >> shift_d;
    aligned_pp = signed_pp[4] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  end

endmodule

module align_acc_scheduler #(
  parameter int N_PP  = 8,
  parameter int ACC_W = 19
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic        [4:0]       in_exp,
  input  logic        [4:0]       in_pp,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_sum,
  output logic        [4:0]       out_exp_max
);

  localparam int IDX_W = $clog2(N_PP);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PP - 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic        [IDX_W-1:0]   idx;
  logic        [4:0]         exp_max;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_nxt;
  logic        [9:0]         buf_mem [N_PP];
  logic        [4:0]         rd_exp;
  logic        [4:0]         rd_pp;
  logic signed [15:0]        aligned_pp;
  logic                      beat_take;
  logic                      idx_last;

  assign beat_take = in_valid && (state == ST_LOAD);
  assign idx_last  = (idx == IDX_LAST);
  assign rd_exp    = buf_mem[idx][9:5];
  assign rd_pp     = buf_mem[idx][4:0];

  align_acc_align u_align (
    .pp_exp     (rd_exp),
    .exp_max    (exp_max),
    .signed_pp  (rd_pp),
    .aligned_pp (aligned_pp)
  );

  // Sign-extend the aligned value into the accumulator width.
  always_comb begin
    acc_nxt = acc + {{(ACC_W-16){aligned_pp[15]}}, aligned_pp};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD:  if (in_valid && idx_last) state_nxt = ST_ALIGN;
      ST_ALIGN: if (idx_last)             state_nxt = ST_DONE;
      ST_DONE:  if (out_ready)            state_nxt = ST_LOAD;
      default:                            state_nxt = ST_LOAD;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_LOAD:  in_ready  = 1'b1;
      ST_DONE:  out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Pair buffer; only read back after being written in the same group, so no reset.
  always_ff @(posedge clk) begin
    if (beat_take) begin
      buf_mem[idx] <= {in_exp, in_pp};
    end
  end

  // Index, exponent tracking, accumulation and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      exp_max     <= '0;
      acc         <= '0;
      out_sum     <= '0;
      out_exp_max <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_valid) begin
            if (in_exp > exp_max) exp_max <= in_exp;
            idx <= idx_last ? '0 : idx + IDX_W'(1);
          end
        end
        ST_ALIGN: begin
          acc <= acc_nxt;
          idx <= idx_last ? '0 : idx + IDX_W'(1);
          if (idx_last) begin
            out_sum     <= acc_nxt;
            out_exp_max <= exp_max;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            idx     <= '0;
            exp_max <= '0;
            acc     <= '0;
          end
        end
        default: begin
          idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_align_acc_scheduler.sv
// Directed bench for align_acc_scheduler. A timeline model predicts the
// handshakes and the group result from plain arithmetic; a literal table pins
// each group result the model produces.
module tb_align_acc_scheduler;

  localparam int N_PP  = 8;
  localparam int ACC_W = 19;
  localparam int N_RES = 7;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    out_ready = 1'b0;
  logic        [4:0]       in_exp = '0;
  logic        [4:0]       in_pp = '0;
  logic                    in_ready;
  logic                    out_valid;
  logic signed [ACC_W-1:0] out_sum;
  logic        [4:0]       out_exp_max;

  int checks = 0;
  int errors = 0;

  align_acc_scheduler #(.N_PP(N_PP), .ACC_W(ACC_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_exp      (in_exp),
    .in_pp       (in_pp),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_exp_max (out_exp_max)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Model state: beats collected, whether a full group is waiting, edges since the last beat.
  int  m_n = 0;
  bit  m_full = 1'b0;
  int  m_edges = 0;
  int  m_sum = 0;
  int  m_emax = 0;
  int  m_exp [N_PP];
  int  m_pp  [N_PP];
  int  res_idx = 0;
  int  lit_sum [N_RES] = '{16384, 4096, 30720, -2048, -16384, 32768, 31743};
  int  lit_exp [N_RES] = '{10, 10, 20, 5, 4, 1, 31};

  function automatic void model_group();
    int d;
    int mag;
    m_emax = 0;
    m_sum  = 0;
    for (int i = 0; i < N_PP; i++)
      if (m_exp[i] > m_emax) m_emax = m_exp[i];
    for (int i = 0; i < N_PP; i++) begin
      d   = m_emax - m_exp[i];
      mag = (d >= 15) ? 0 : (((m_pp[i] % 16) * 2048) >> d);
      m_sum += (m_pp[i] >= 16) ? -mag : mag;
    end
  endfunction

  // Compare DUT against the model every cycle, then advance the model over the next edge.
  always @(negedge clk) begin
    bit exp_ov;
    if (!rst_n) begin
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_sum", int'(out_sum), 0);
      chk("rst_out_exp_max", int'(out_exp_max), 0);
      m_n = 0; m_full = 1'b0; m_edges = 0;
    end else begin
      exp_ov = m_full && (m_edges >= N_PP);
      chk("in_ready", int'(in_ready), m_full ? 0 : 1);
      chk("out_valid", int'(out_valid), exp_ov ? 1 : 0);
      if (exp_ov) begin
        chk("out_sum", int'(out_sum), m_sum);
        chk("out_exp_max", int'(out_exp_max), m_emax);
      end
      if (m_full) begin
        if (exp_ov && out_ready) begin
          if (res_idx < N_RES) begin
            chk("lit_sum", m_sum, lit_sum[res_idx]);
            chk("lit_exp", m_emax, lit_exp[res_idx]);
          end
          res_idx++;
          m_full = 1'b0;
          m_n = 0;
        end else if (!exp_ov) begin
          m_edges++;
        end
      end else if (in_valid) begin
        m_exp[m_n] = int'(in_exp);
        m_pp[m_n]  = int'(in_pp);
        m_n++;
        if (m_n == N_PP) begin
          model_group();
          m_full = 1'b1;
          m_edges = 0;
        end
      end
    end
  end

  task automatic send_beat(input logic [4:0] e, input logic [4:0] p);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_exp   = e;
    in_pp    = p;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 60) begin
        errors++;
        $display("FAIL beat_timeout in_ready=%0b required=1", in_ready);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_same(input int n, input logic [4:0] e, input logic [4:0] p);
    for (int i = 0; i < n; i++) send_beat(e, p);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;

    // 1: equal exponents, +1 each
    send_same(8, 5'd10, 5'h01);
    // 2: positive and negative with a small exponent gap
    send_beat(5'd10, 5'h03);
    send_beat(5'd8,  5'h14);
    send_same(6, 5'd10, 5'h00);
    // 3: gap of 17 flushes the small pairs
    send_beat(5'd20, 5'h0F);
    send_same(7, 5'd3, 5'h0F);
    // 4: negative zero contributes nothing
    send_beat(5'd5, 5'h10);
    send_beat(5'd5, 5'h11);
    send_same(6, 5'd5, 5'h00);
    // 5: result held with out_ready low while the next group waits
    send_beat(5'd4, 5'h11);
    out_ready = 1'b0;
    send_same(7, 5'd4, 5'h11);
    fork
      begin
        int w;
        w = 0;
        forever begin
          @(negedge clk);
          if (out_valid) break;
          w++;
          if (w > 40) begin
            errors++;
            $display("FAIL result_timeout out_valid=%0b required=1", out_valid);
            break;
          end
        end
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      send_same(8, 5'd7, 5'h05);
    join
    // 6: abort that group in ALIGN at idx 3, then a fresh group
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send_same(8, 5'd1, 5'h02);
    // 7: exponent gaps of 0, 14, 15 and 1
    send_beat(5'd31, 5'h0F);
    send_beat(5'd17, 5'h1F);
    send_beat(5'd16, 5'h08);
    send_beat(5'd30, 5'h01);
    send_same(4, 5'd0, 5'h00);

    for (int w = 0; w < 40 && res_idx < N_RES; w++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("result_count", res_idx, N_RES);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
